uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder_pkg.sv | 26 ++
 rtl/uart_tx_feeder_if.sv | 37 +++
 rtl/uart_tx_feeder_sync_fifo.sv | 71 +++++++
 rtl/uart_tx_feeder.sv | 120 ++++++++++++
 tb/tb_uart_tx_feeder.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// rtl/uart_tx_feeder_pkg.sv - shared types and helpers for the UART transmit feeder
//
// Purpose: feeder FSM state encoding and the clog2 width helper used by
//          the feeder, its FIFO and the bench.
// Ports:   none (package).

package uart_tx_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LAUNCH     = 2'd1,
    WAIT_BUSY  = 2'd2,
    WAIT_READY = 2'd3
  } feeder_state_t;

  // Bits needed to index 'value' entries; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - character stream and transmitter handshake bundle
//
// Purpose: groups the receiver-side character strobe and the transmitter
//          launch handshake of the UART transmit feeder.
// Signals: in_valid/in_data  - one-cycle character strobe from the receiver
//          tx_rdy            - transmitter idle and able to take a character
//          tx_new_data       - one-cycle launch strobe to the transmitter
//          tx_char           - character presented to the transmitter
// Modports: master = character source + transmitter side, slave = feeder.

interface uart_tx_feeder_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             tx_rdy;
  logic             tx_new_data;
  logic [WIDTH-1:0] tx_char;

  modport master (
    output in_valid,
    output in_data,
    output tx_rdy,
    input  tx_new_data,
    input  tx_char
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  tx_rdy,
    output tx_new_data,
    output tx_char
  );

endinterface

// File: rtl/uart_tx_feeder_sync_fifo.sv
// rtl/uart_tx_feeder_sync_fifo.sv - synchronous character FIFO for the transmit feeder
//
// Purpose: DEPTH-entry show-ahead FIFO; dout always presents the head entry.
// Ports:   clk, rst_n      - clock, asynchronous active-low reset
//          push, din       - enqueue request (ignored when full)
//          pop, dout       - dequeue request (ignored when empty), head data
//          full, empty     - registered occupancy flags
//          count           - registered occupancy, 0..DEPTH

module sync_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 full,
  output logic                 empty,
  output logic [clog2(DEPTH):0] count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_nxt;
  logic [AW:0]      rd_nxt;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign wr_nxt = do_push ? wr_ptr + 1'b1 : wr_ptr;
  assign rd_nxt = do_pop  ? rd_ptr + 1'b1 : rd_ptr;

  assign dout = mem[rd_ptr[AW-1:0]];

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Flags come from the next pointers so they are valid right after the edge.
  // The extra pointer MSB separates full (MSBs differ) from empty (equal).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count  <= wr_nxt - rd_nxt;
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      empty  <= (wr_nxt == rd_nxt);
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - queues received characters and launches them into a UART transmitter
//
// Purpose: buffers characters in a FIFO and hands them one at a time to a
//          transmitter, waiting for the transmitter to go busy and then idle
//          between launches; flags dropped pushes and unacknowledged launches.
// Ports:   clk, rst_n - clock, asynchronous active-low reset
//          bus        - uart_tx_feeder_if.slave (in_valid, in_data, tx_rdy,
//                       tx_new_data, tx_char)
//          full, empty, count - FIFO occupancy
//          overflow   - sticky, a push was dropped
//          ack_err    - sticky, a launch was never acknowledged

module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_tx_feeder_if.slave       bus,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  ack_err
);

  localparam int            TW        = clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] ACK_LIMIT = TW'(ACK_TIMEOUT);

  feeder_state_t    state_q;
  feeder_state_t    state_d;
  logic [TW-1:0]    tmo_q;
  logic [TW-1:0]    tmo_d;
  logic [WIDTH-1:0] tx_char_q;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_pop;
  logic             ack_set;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.in_valid),
    .pop   (fifo_pop),
    .din   (bus.in_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      tx_char_q <= '0;
      overflow  <= 1'b0;
      ack_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (fifo_pop) begin
        tx_char_q <= fifo_dout;
      end
      if (bus.in_valid && full) begin
        overflow <= 1'b1;
      end
      if (ack_set) begin
        ack_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    fifo_pop = 1'b0;
    ack_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && bus.tx_rdy) begin
          fifo_pop = 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // The transmitter must drop tx_rdy to show it took the character;
        // if it never does, give up on it rather than relaunch.
        if (!bus.tx_rdy) begin
          state_d = WAIT_READY;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == ACK_LIMIT) begin
            ack_set = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_READY: begin
        if (bus.tx_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_new_data = (state_q == LAUNCH);
  assign bus.tx_char     = tx_char_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - scoreboard bench for uart_tx_feeder

module tb_uart_tx_feeder;
  import uart_tx_feeder_pkg::*;

  localparam int WIDTH       = 8;
  localparam int DEPTH       = 16;
  localparam int ACK_TIMEOUT = 4;
  localparam int CW          = clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ack_err;

  uart_tx_feeder_if #(.WIDTH(WIDTH)) bus ();

  uart_tx_feeder #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .ack_err  (ack_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [WIDTH-1:0] exp_q[$];
  int  occ     = 0;
  bit  exp_ovf = 0;
  bit  exp_ack = 0;
  int  peak    = 0;
  bit  prev_tnd = 0;

  // Transmitter model controls and state
  bit online  = 1;
  bit stuck   = 0;
  bit rand_tx = 0;
  int ack_d   = 1;
  int busy_b  = 3;
  int xs      = 0;
  int xcnt    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Occupancy model: a launch seen now means a pop on the previous edge;
  // a push on the coming edge is accepted only if the FIFO is not full now.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      occ     = 0;
      exp_ovf = 0;
      exp_ack = 0;
    end else begin
      if (bus.tx_new_data) occ--;
      check("count", count, occ);
      check("full", full, occ == DEPTH);
      check("empty", empty, occ == 0);
      check("overflow", overflow, exp_ovf);
      if (int'(count) > peak) peak = int'(count);
      if (bus.in_valid) begin
        if (occ < DEPTH) begin
          occ++;
          exp_q.push_back(bus.in_data);
        end else begin
          exp_ovf = 1;
        end
      end
    end
  end

  // Monitor: every launch must carry the oldest accepted character.
  always @(negedge clk) begin
    if (rst_n && bus.tx_new_data) begin
      check("pulse_width", prev_tnd, 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_launch: got char %0h expected no launch at %0t", bus.tx_char, $time);
      end else begin
        check("tx_char", bus.tx_char, exp_q.pop_front());
      end
    end
    prev_tnd = rst_n && bus.tx_new_data;
  end

  // Transmitter model: after a launch waits ack_d cycles, then is busy busy_b cycles.
  initial begin
    bus.tx_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        xs = 0;
        bus.tx_rdy = online;
      end else begin
        if (bus.tx_new_data) check("launch_when_ready", (xs == 0) && bus.tx_rdy, 1);
        case (xs)
          0: begin
            if (bus.tx_new_data) begin
              if (rand_tx) begin
                ack_d  = $urandom_range(0, ACK_TIMEOUT);
                busy_b = $urandom_range(1, 8);
              end
              if (stuck) begin
                exp_ack = 1;
              end else if (ack_d == 0) begin
                bus.tx_rdy = 1'b0;
                xs = 2;
                xcnt = busy_b;
              end else begin
                xs = 1;
                xcnt = ack_d;
              end
            end else begin
              bus.tx_rdy = online;
            end
          end
          1: begin
            xcnt--;
            if (xcnt == 0) begin
              bus.tx_rdy = 1'b0;
              xs = 2;
              xcnt = busy_b;
            end
          end
          default: begin
            xcnt--;
            if (xcnt == 0) begin
              xs = 0;
              bus.tx_rdy = online;
            end
          end
        endcase
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_char(input logic [WIDTH-1:0] c);
    bus.in_valid = 1'b1;
    bus.in_data  = c;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !empty || xs != 0 || bus.tx_new_data) && guard < 3000) begin
      idle(1);
      guard++;
    end
    check("drain_in_time", guard < 3000, 1);
    idle(ACK_TIMEOUT + 4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_tx_new_data"}, bus.tx_new_data, 0);
    check({tag, "_tx_char"}, bus.tx_char, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_ack_err"}, ack_err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(2);

    // Single character and launch latency
    push_char(8'h41);
    @(negedge clk);
    check("lat_pop_cycle", bus.tx_new_data, 0);
    @(negedge clk);
    check("lat_launch", bus.tx_new_data, 1);
    check("lat_char", bus.tx_char, 8'h41);
    idle(1);
    drain();

    // Burst against a slow transmitter
    busy_b = 10;
    peak = 0;
    push_char(8'h48);
    push_char(8'h65);
    push_char(8'h6C);
    push_char(8'h6C);
    push_char(8'h6F);
    drain();
    check("burst_peak", peak, 4);
    busy_b = 3;

    // Overflow with the transmitter offline
    online = 0;
    idle(2);
    for (int i = 0; i < DEPTH; i++) push_char(8'(i));
    check("full_after_depth", full, 1);
    check("no_ovf_yet", overflow, 0);
    push_char(8'h10);
    check("ovf_after_drop", overflow, 1);
    check("count_after_drop", count, DEPTH);
    online = 1;
    drain();

    // Push on the same edge as a pop with three queued
    online = 0;
    idle(2);
    for (int i = 0; i < 3; i++) push_char(8'($urandom));
    check("pre_simul_count", count, 3);
    online = 1;
    push_char(8'hC3);
    check("simul_count", count, 3);
    drain();

    // Transmitter never acknowledges
    stuck = 1;
    push_char(8'hA5);
    push_char(8'h5A);
    @(negedge clk);
    check("noack_launch1", bus.tx_new_data, 1);
    repeat (4) @(negedge clk);
    check("noack_before_timeout", ack_err, 0);
    @(negedge clk);
    check("noack_at_timeout", ack_err, 1);
    @(negedge clk);
    check("noack_launch2", bus.tx_new_data, 1);
    check("noack_char2", bus.tx_char, 8'h5A);
    idle(1);
    drain();
    stuck = 0;
    idle(2);
    check("ack_err_sticky", ack_err, exp_ack);

    // Randomized traffic with randomized transmitter timing
    rand_tx = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 40) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) online = !online;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    online = 1;
    drain();
    check("rand_ack_err", ack_err, exp_ack);
    rand_tx = 0;

    // Reset while waiting for the transmitter with five queued
    ack_d  = 1;
    busy_b = 60;
    for (int i = 0; i < 6; i++) push_char(8'h20 + 8'(i));
    idle(3);
    check("pre_reset_count", count, 5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midop_reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    busy_b = 3;
    idle(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("quiet_after_reset", bus.tx_new_data, 0);
    end
    idle(1);
    push_char(8'h7E);
    drain();
    check("final_ack_err", ack_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
